gp_chain_serial: RTL and testbench
==================================

GP_CHAIN_SERIAL -- requirements
Module: gp_chain_serial

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter N_STAGES, default 5: stages per frame, legal range 2..15.
REQ-003 Parameter IDX_W, default 4: width of the stage index.
REQ-004 Port clk  input  1: the single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1: synchronous, active-high reset.
REQ-006 Port in_valid  input  1: an input stage beat is presented.
REQ-007 Port in_ready  output  1: the block accepts the beat this cycle.
REQ-008 Port in_first  input  1: the beat is stage 0 of a new frame.
REQ-009 Port in_seed  input  1: chain seed; sampled only on beats with in_first=1.
REQ-010 Port in_g  input  1: stage generate term.
REQ-011 Port in_p  input  1: stage propagate term.
REQ-012 Port out_valid  output  1: an output stage result is presented.
REQ-013 Port out_ready  input  1: the consumer accepts the result this cycle.
REQ-014 Port out_chain  output  1: chain value after this stage.
REQ-015 Port out_idx  output  IDX_W: stage number of this result, 0..N_STAGES-1.
REQ-016 Port out_last  output  1: this result is stage N_STAGES-1.
REQ-017 Port busy  output  1: a frame is in progress (state RUN).
REQ-018 Port err_frame  output  1: one-cycle pulse on a framing error.

Function
REQ-019 A beat SHALL be accepted when in_valid=1 and in_ready=1 in the same cycle; a result SHALL be consumed when out_valid=1 and out_ready=1 in the same cycle.
REQ-020 in_ready SHALL equal (!out_valid | out_ready) and SHALL be purely combinational from these signals.
REQ-021 Stage arithmetic SHALL be chain_k = g_k | (p_k & chain_{k-1}). chain_{-1} is in_seed of the in_first beat.
REQ-022 An accepted, non-discarded beat SHALL load out_valid=1, out_chain, out_idx and out_last in the following cycle, giving 1-cycle latency.
REQ-023 Each loaded out_chain value SHALL also be stored as the running chain for the next stage.
REQ-024 A result SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 out_valid SHALL drop after consumption unless a new beat is accepted in the same cycle. Back-to-back throughput SHALL be one beat per cycle.
REQ-026 The FSM SHALL have two states, IDLE and RUN. busy SHALL be 1 exactly in RUN.
REQ-027 IDLE, accepted beat with in_first=1: the block SHALL emit stage 0, set index to 1 and go to RUN.
REQ-028 IDLE, accepted beat with in_first=0: the block SHALL discard the beat (no output), pulse err_frame, and stay in IDLE.
REQ-029 RUN, accepted beat with in_first=0: the block SHALL emit the stage at the current index and increment the index.
REQ-030 The stage at index N_STAGES-1 SHALL set out_last=1, reset the index to 0 and return to IDLE.
REQ-031 RUN, accepted beat with in_first=1: the block SHALL abandon the current frame, pulse err_frame, and process the beat as stage 0 of a new frame with the new seed. State SHALL remain RUN.
REQ-032 Results already loaded SHALL NOT be altered by the abort in REQ-031.
REQ-033 The index counter SHALL NOT wrap past N_STAGES-1.
REQ-034 The g and p inputs SHALL be ignored when no beat is accepted. in_seed SHALL be ignored on beats with in_first=0.

Reset
REQ-035 While rst=1, the block SHALL force: out_valid=0, out_chain=0, out_idx=0, out_last=0, busy=0, err_frame=0, state=IDLE, index=0, running chain=0.
REQ-036 While rst=1, in_ready SHALL read 1 per REQ-020, but beats presented SHALL NOT be accepted.
REQ-037 Reset asserted mid-frame SHALL discard the partial frame. The first accepted beat after reset SHALL require in_first=1.

Verification
REQ-038 Frame, N_STAGES=5, out_ready=1, seed=1, (g,p) = (0,1),(0,0),(1,0),(0,1),(0,1) -> out_chain 1,0,1,1,1; out_idx 0..4; out_last only at idx 4; then busy=0.
REQ-039 Same frame with out_ready low for 3 cycles at idx 2 -> idx 2 result held stable; in_ready=0 during the stall; no beat lost; sequence unchanged.
REQ-040 In IDLE, beat with in_first=0 -> no out_valid, one err_frame pulse; a following valid frame processes normally.
REQ-041 in_first beat at idx 3 with seed=0, (g,p)=(0,1) -> err_frame pulse, out_chain=0, out_idx=0; the next 4 beats complete the new frame with out_last at idx 4.
REQ-042 rst asserted at idx 2 -> next cycle all outputs 0 and busy=0; a beat with in_first=0 then gives err_frame.
REQ-043 N_STAGES=2, continuous back-to-back frames -> one result per cycle, out_last on every second result.

Source files
------------

// File: rtl/gp_chain_serial.sv
// gp_chain_serial: one bit-serial generate/propagate chain stage per beat.
// Each accepted beat computes chain_k = g_k | (p_k & chain_{k-1}) and
// presents it one cycle later through a single-entry valid/ready output
// register. A two-state framer tracks the stage index and flags framing
// errors: a non-first beat while idle, or a new first beat mid-frame.
module gp_chain_serial #(
    parameter int N_STAGES = 5,
    parameter int IDX_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_first,
    input  logic             in_seed,
    input  logic             in_g,
    input  logic             in_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_chain,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             busy,
    output logic             err_frame
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STAGES - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             chain;

    logic             accept;
    logic             discard;
    logic             abort;
    logic             prev_chain;
    logic             stage_chain;
    logic [IDX_W-1:0] stage_idx;

    // The output register can take a new beat when empty or draining this cycle.
    assign in_ready = !out_valid || out_ready;
    // A beat presented during reset is never taken, even though in_ready may read 1.
    assign accept   = in_valid && in_ready && !rst;
    assign discard  = (state == IDLE) && !in_first;
    assign abort    = (state == RUN) && in_first;
    assign busy     = (state == RUN);

    // Select the stage being computed: a first beat restarts from the seed at index 0.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch so no
        // path can leave it unassigned, which would infer a latch.
        prev_chain = chain;
        stage_idx  = idx;
        if (in_first) begin
            prev_chain = in_seed;
            stage_idx  = '0;
        end
        stage_chain = in_g | (in_p & prev_chain);
    end

    // Framer FSM, running chain and the registered output stage.
    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            chain     <= 1'b0;
            out_valid <= 1'b0;
            out_chain <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            err_frame <= 1'b0;
        end else begin
            err_frame <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (discard) begin
                    err_frame <= 1'b1;
                end else begin
                    err_frame <= abort;
                    out_valid <= 1'b1;
                    out_chain <= stage_chain;
                    out_idx   <= stage_idx;
                    out_last  <= (stage_idx == LAST_IDX);
                    chain     <= stage_chain;
                    if (stage_idx == LAST_IDX) begin
                        idx   <= '0;
                        state <= IDLE;
                    end else begin
                        idx   <= stage_idx + 1'b1;
                        state <= RUN;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_gp_chain_serial.sv
// Bench for gp_chain_serial: a spec-level scoreboard predicts every output
// of the default (5-stage) instance, directed checks pin the documented
// sequences, and a second 2-stage instance streams back-to-back frames.
module tb_gp_chain_serial;

    localparam int N1 = 5;
    localparam int N2 = 2;

    typedef struct {
        logic       chain;
        logic [3:0] idx;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic       in_valid, in_ready, in_first, in_seed, in_g, in_p;
    logic       out_valid, out_ready, out_chain, out_last, busy, err_frame;
    logic [3:0] out_idx;

    logic       d2_in_valid, d2_in_ready, d2_in_first, d2_in_seed, d2_in_g, d2_in_p;
    logic       d2_out_valid, d2_out_ready, d2_out_chain, d2_out_last, d2_busy, d2_err_frame;
    logic [3:0] d2_out_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gp_chain_serial #(.N_STAGES(N1), .IDX_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
        .in_seed(in_seed), .in_g(in_g), .in_p(in_p),
        .out_valid(out_valid), .out_ready(out_ready), .out_chain(out_chain),
        .out_idx(out_idx), .out_last(out_last), .busy(busy), .err_frame(err_frame)
    );

    gp_chain_serial #(.N_STAGES(N2), .IDX_W(4)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_first(d2_in_first),
        .in_seed(d2_in_seed), .in_g(d2_in_g), .in_p(d2_in_p),
        .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_chain(d2_out_chain),
        .out_idx(d2_out_idx), .out_last(d2_out_last), .busy(d2_busy), .err_frame(d2_err_frame)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard model of the 5-stage instance, sampled mid-cycle.
    exp_t q[$];
    bit   mon_en  = 1'b0;
    bit   m_run   = 1'b0;
    int   m_idx   = 0;
    logic m_chain = 1'b0;
    logic m_err   = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_ready;
            logic prev;
            int   k;
            exp_t e;
            exp_ready = (q.size() == 0) || out_ready;
            check("sb_in_ready", 32'(in_ready), 32'(exp_ready));
            check("sb_out_valid", 32'(out_valid), 32'(q.size() != 0));
            check("sb_busy", 32'(busy), 32'(m_run));
            check("sb_err_frame", 32'(err_frame), 32'(m_err));
            if (q.size() != 0) begin
                check("sb_out_chain", 32'(out_chain), 32'(q[0].chain));
                check("sb_out_idx", 32'(out_idx), 32'(q[0].idx));
                check("sb_out_last", 32'(out_last), 32'(q[0].last));
                if (out_ready) void'(q.pop_front());
            end
            m_err = 1'b0;
            if (rst) begin
                q.delete();
                m_run   = 1'b0;
                m_idx   = 0;
                m_chain = 1'b0;
            end else if (in_valid && exp_ready) begin
                if (!m_run && !in_first) begin
                    m_err = 1'b1;
                end else begin
                    m_err   = m_run && in_first;
                    prev    = in_first ? in_seed : m_chain;
                    k       = in_first ? 0 : m_idx;
                    e.chain = in_g | (in_p & prev);
                    e.idx   = 4'(k);
                    e.last  = (k == N1 - 1);
                    q.push_back(e);
                    m_chain = e.chain;
                    if (k == N1 - 1) begin
                        m_idx = 0;
                        m_run = 1'b0;
                    end else begin
                        m_idx = k + 1;
                        m_run = 1'b1;
                    end
                end
            end
        end
    end

    // Present one beat to the 5-stage instance; returns just after it is taken.
    task automatic beat(input logic f, input logic s, input logic g, input logic p);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_first = f;
        in_seed  = s;
        in_g     = g;
        in_p     = p;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 32'(n < 20), 32'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'($urandom);
        in_seed  = 1'($urandom);
        in_g     = 1'($urandom);
        in_p     = 1'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic e_chain;
        logic g2;
        logic p2;
        logic s2;
        logic f2;

        rst = 1'b1;
        in_valid = 1'b1; in_first = 1'b1; in_seed = 1'b1; in_g = 1'b1; in_p = 1'b1;
        out_ready = 1'b1;
        d2_in_valid = 1'b0; d2_in_first = 1'b0; d2_in_seed = 1'b0;
        d2_in_g = 1'b0; d2_in_p = 1'b0; d2_out_ready = 1'b1;

        // Reset with a beat held on the input: it must not be taken.
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_chain", 32'(out_chain), 32'(0));
        check("rst_out_idx", 32'(out_idx), 32'(0));
        check("rst_out_last", 32'(out_last), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_err", 32'(err_frame), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));
        in_valid = 1'b0;
        rst = 1'b0;
        idle(1);

        // Reference frame: seed 1 -> chain 1,0,1,1,1.
        beat(1, 1, 0, 1);
        check("f1_c0", 32'(out_chain), 32'(1)); check("f1_i0", 32'(out_idx), 32'(0));
        check("f1_busy", 32'(busy), 32'(1));
        beat(0, 0, 0, 0);
        check("f1_c1", 32'(out_chain), 32'(0)); check("f1_l1", 32'(out_last), 32'(0));
        beat(0, 0, 1, 0);
        check("f1_c2", 32'(out_chain), 32'(1)); check("f1_i2", 32'(out_idx), 32'(2));
        beat(0, 0, 0, 1);
        check("f1_c3", 32'(out_chain), 32'(1)); check("f1_l3", 32'(out_last), 32'(0));
        beat(0, 0, 0, 1);
        check("f1_c4", 32'(out_chain), 32'(1)); check("f1_i4", 32'(out_idx), 32'(4));
        check("f1_l4", 32'(out_last), 32'(1));
        idle(1);
        check("f1_idle_busy", 32'(busy), 32'(0));

        // Same frame with a 3-cycle consumer stall on the idx 2 result.
        beat(1, 1, 0, 1);
        beat(0, 0, 0, 0);
        beat(0, 0, 1, 0);
        out_ready = 1'b0;
        in_valid = 1'b1; in_first = 1'b0; in_seed = 1'b0; in_g = 1'b0; in_p = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_idx", 32'(out_idx), 32'(2));
            check("stall_chain", 32'(out_chain), 32'(1));
            check("stall_ready", 32'(in_ready), 32'(0));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        beat(0, 0, 0, 1);
        check("stall_c3", 32'(out_chain), 32'(1)); check("stall_i3", 32'(out_idx), 32'(3));
        beat(0, 0, 0, 1);
        check("stall_l4", 32'(out_last), 32'(1));
        idle(1);

        // Non-first beat while idle is discarded with an error pulse.
        beat(0, 1, 1, 1);
        check("idle_err", 32'(err_frame), 32'(1));
        check("idle_no_out", 32'(out_valid), 32'(0));
        idle(1);
        check("idle_err_drop", 32'(err_frame), 32'(0));
        beat(1, 0, 1, 0);
        beat(0, 0, 0, 1);
        beat(0, 0, 0, 0);
        beat(0, 0, 1, 1);
        beat(0, 0, 0, 1);
        check("after_err_last", 32'(out_last), 32'(1));
        check("after_err_chain", 32'(out_chain), 32'(1));
        idle(1);

        // Restart mid-frame at idx 3 with seed 0.
        beat(1, 1, 1, 1);
        beat(0, 0, 0, 1);
        beat(0, 0, 1, 0);
        beat(1, 0, 0, 1);
        check("abort_err", 32'(err_frame), 32'(1));
        check("abort_chain", 32'(out_chain), 32'(0));
        check("abort_idx", 32'(out_idx), 32'(0));
        check("abort_busy", 32'(busy), 32'(1));
        beat(0, 1, 1, 0);
        beat(0, 0, 0, 1);
        beat(0, 0, 0, 0);
        beat(0, 0, 0, 1);
        check("abort_last", 32'(out_last), 32'(1));
        check("abort_last_idx", 32'(out_idx), 32'(4));
        idle(2);

        // Reset at idx 2 drops the partial frame.
        beat(1, 1, 0, 1);
        beat(0, 0, 1, 1);
        beat(0, 0, 0, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mrst_valid", 32'(out_valid), 32'(0));
        check("mrst_chain", 32'(out_chain), 32'(0));
        check("mrst_idx", 32'(out_idx), 32'(0));
        check("mrst_busy", 32'(busy), 32'(0));
        beat(0, 1, 1, 1);
        check("mrst_err", 32'(err_frame), 32'(1));
        check("mrst_no_out", 32'(out_valid), 32'(0));
        idle(1);

        // Two-stage instance: back-to-back frames, one result per cycle.
        e_chain = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f2 = (i % 2 == 0);
            s2 = 1'((i / 2) % 2);
            g2 = (i % 8 == 5);
            p2 = (i % 3 != 0);
            d2_in_valid = 1'b1; d2_in_first = f2; d2_in_seed = s2;
            d2_in_g = g2; d2_in_p = p2;
            e_chain = g2 | (p2 & (f2 ? s2 : e_chain));
            @(posedge clk); #1;
            check("n2_valid", 32'(d2_out_valid), 32'(1));
            check("n2_idx", 32'(d2_out_idx), 32'(i % 2));
            check("n2_last", 32'(d2_out_last), 32'(i % 2));
            check("n2_chain", 32'(d2_out_chain), 32'(e_chain));
            check("n2_err", 32'(d2_err_frame), 32'(0));
        end
        d2_in_valid = 1'b0;
        idle(1);
        check("n2_drain", 32'(d2_out_valid), 32'(0));
        check("n2_busy", 32'(d2_busy), 32'(0));

        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
